// File: rtl/four_bit_1to2_demux_buf.sv
// Registered 1-to-2 demux: each input word is routed by in_sel into one of two DEPTH-entry FIFOs.
// Optional per-channel delivered-word counters are enabled with the DEMUX_COUNT_EN macro.
module four_bit_1to2_demux_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]       a_count,
    output logic [7:0]       b_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Index 0 is channel A, index 1 is channel B.
    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [WIDTH-1:0] mem_d  [2][DEPTH];
    logic [PTR_W-1:0] wptr_q [2];
    logic [PTR_W-1:0] wptr_d [2];
    logic [PTR_W-1:0] rptr_q [2];
    logic [PTR_W-1:0] rptr_d [2];
    logic [OCC_W-1:0] occ_q  [2];
    logic [OCC_W-1:0] occ_d  [2];
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;

    assign out_ready = {b_ready, a_ready};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c] = (occ_q[c] == OCC_FULL);
            pop[c]  = (occ_q[c] != '0) && out_ready[c];
        end
        // No full-bypass: a full channel refuses a push even while it is being popped.
        in_ready = resetn && !full[in_sel];
        push[0]  = in_valid && in_ready && !in_sel;
        push[1]  = in_valid && in_ready && in_sel;
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_d[c][wptr_q[c]] = in_data;
                wptr_d[c]           = wptr_q[c] + PTR_ONE;
            end
            if (pop[c]) begin
                rptr_d[c] = rptr_q[c] + PTR_ONE;
            end
            if (push[c] && !pop[c]) begin
                occ_d[c] = occ_q[c] + OCC_ONE;
            end else if (pop[c] && !push[c]) begin
                occ_d[c] = occ_q[c] - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                occ_q[c]  <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    assign a_valid = (occ_q[0] != '0);
    assign b_valid = (occ_q[1] != '0);
    assign a_data  = mem_q[0][rptr_q[0]];
    assign b_data  = mem_q[1][rptr_q[1]];

`ifdef DEMUX_COUNT_EN
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];

    // Counters wrap naturally at 255 -> 0.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = pop[c] ? cnt_q[c] + 8'd1 : cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign a_count = cnt_q[0];
    assign b_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_four_bit_1to2_demux_buf.sv
// Directed-vector bench for four_bit_1to2_demux_buf; count checks run when DEMUX_COUNT_EN is defined.
module tb_four_bit_1to2_demux_buf;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [3:0] in_data;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [3:0] a_data, b_data;
`ifdef DEMUX_COUNT_EN
    logic [7:0] a_count, b_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    four_bit_1to2_demux_buf #(.WIDTH(4), .DEPTH(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
`ifdef DEMUX_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag, input logic [7:0] ea, input logic [7:0] eb);
`ifdef DEMUX_COUNT_EN
        chk({tag, "_a_count"}, {24'd0, a_count}, {24'd0, ea});
        chk({tag, "_b_count"}, {24'd0, b_count}, {24'd0, eb});
`else
        if (tag.len() == 0 && ea == eb) begin end
`endif
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
        a_ready = 1'b0; b_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_a_data", {28'd0, a_data}, 32'd0);
        chk("rst_b_data", {28'd0, b_data}, 32'd0);
        chk_counts("rst", 8'd0, 8'd0);

        resetn = 1'b1; in_valid = 1'b0;
        step();
        chk("idle_a_valid", {31'd0, a_valid}, 32'd0);

        // Routing
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b0010;
        #1 chk("route_in_ready_a", {31'd0, in_ready}, 32'd1);
        step();
        chk("route_a_valid", {31'd0, a_valid}, 32'd1);
        chk("route_a_data", {28'd0, a_data}, 32'h2);
        in_sel = 1'b1; in_data = 4'b0011;
        #1 chk("route_in_ready_b", {31'd0, in_ready}, 32'd1);
        step();
        chk("route_a_drained", {31'd0, a_valid}, 32'd0);
        chk("route_b_valid", {31'd0, b_valid}, 32'd1);
        chk("route_b_data", {28'd0, b_data}, 32'h3);
        in_valid = 1'b0;
        step();
        chk("route_b_drained", {31'd0, b_valid}, 32'd0);
        chk_counts("route", 8'd1, 8'd1);

        // Fill A under backpressure
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b0100;
        step();
        in_data = 4'b0111;
        step();
        chk("full_a_head", {28'd0, a_data}, 32'h4);
        in_data = 4'b1001;
        #1 chk("full_in_ready_a", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b1; in_data = 4'b1111;
        #1 chk("full_in_ready_b", {31'd0, in_ready}, 32'd1);
        step();
        chk("full_b_valid", {31'd0, b_valid}, 32'd1);
        chk("full_b_data", {28'd0, b_data}, 32'hf);
        chk("full_a_held", {28'd0, a_data}, 32'h4);
        in_valid = 1'b0; b_ready = 1'b1;
        step();
        chk("full_b_drained", {31'd0, b_valid}, 32'd0);
        b_ready = 1'b0;

        // Pop on full A while a push to A is offered: push refused
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b1001; a_ready = 1'b1;
        #1 chk("pp_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("pp_a_valid", {31'd0, a_valid}, 32'd1);
        chk("pp_a_data", {28'd0, a_data}, 32'h7);
        in_valid = 1'b0;
        step();
        chk("pp_a_empty", {31'd0, a_valid}, 32'd0);
        chk_counts("pp", 8'd3, 8'd2);

        // Stream 10 words through A, exercising pointer wrap
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = 4'(i);
            #1 chk($sformatf("wrap_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("wrap_valid_%0d", i), {31'd0, a_valid}, 32'd1);
            chk($sformatf("wrap_data_%0d", i), {28'd0, a_data}, i);
        end
        in_valid = 1'b0;
        step();
        chk("wrap_end_empty", {31'd0, a_valid}, 32'd0);
        chk_counts("wrap", 8'd13, 8'd2);

        // Mid-operation reset discards buffered words
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hA;
        step();
        in_data = 4'hB;
        step();
        chk("mid_a_valid", {31'd0, a_valid}, 32'd1);
        chk("mid_a_data", {28'd0, a_data}, 32'hA);
        in_valid = 1'b0; resetn = 1'b0;
        step();
        chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_rst_a_data", {28'd0, a_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk_counts("mid_rst", 8'd0, 8'd0);
        resetn = 1'b1; a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_a_valid_%0d", i), {31'd0, a_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
